// File: rtl/jtag_uart_bridge_if.sv
// rtl/jtag_uart_bridge_if.sv - Avalon-MM bus between the bridge (master) and the JTAG UART (slave)
interface jtag_uart_bridge_if;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, writedata, write, read,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, writedata, write, read,
    output waitrequest, readdata
  );
endinterface

// File: rtl/jtag_uart_bridge.sv
// rtl/jtag_uart_bridge.sv - Avalon-MM poller bridging a JTAG UART to CPU peek/consume byte streams
// Optional CR insertion before each LF is enabled by defining JTAG_BRIDGE_CRLF_EN.
module jtag_uart_bridge #(
  parameter int RX_LOG     = 4,
  parameter int TX_LOG     = 4,
  parameter int POLL_GAP   = 16,
  parameter int CREDIT_MAX = 64
) (
  input  logic               clock,
  input  logic               reset,
  jtag_uart_bridge_if.master av,
  input  logic               in_canPeek,
  input  logic [7:0]         in_peek,
  output logic               in_consume_en,
  output logic               out_canPeek,
  output logic [7:0]         out_peek,
  input  logic               out_consume_en
);
  localparam int RX_DEPTH = 1 << RX_LOG;
  localparam int TX_DEPTH = 1 << TX_LOG;
  localparam logic [RX_LOG:0] RX_FULL  = (RX_LOG+1)'(RX_DEPTH);
  localparam logic [TX_LOG:0] TX_FULL  = (TX_LOG+1)'(TX_DEPTH);
  localparam logic [15:0]     GAP_W    = 16'(POLL_GAP);
  localparam logic [15:0]     CREDIT_W = 16'(CREDIT_MAX);

  typedef enum logic [1:0] {IDLE, RD_DATA, RD_CTRL, WR_DATA} state_t;
  state_t state, state_nxt;

  logic [7:0]        rx_mem [RX_DEPTH];
  logic [7:0]        tx_mem [TX_DEPTH];
  logic [RX_LOG-1:0] rx_rd, rx_wr;
  logic [TX_LOG-1:0] tx_rd, tx_wr;
  logic [RX_LOG:0]   rx_count;
  logic [TX_LOG:0]   tx_count;
  logic [15:0]       credit, backoff, wspace;
  logic              rr_tx;
  logic              done, rx_push, rx_pop, tx_push, tx_pop;
  logic              rx_elig, tx_elig, pick_tx, crlf_insert;
  logic [7:0]        tx_head, wr_byte;
  logic              unused_rd_bits;

  assign unused_rd_bits = ^av.readdata[14:8];
  assign wspace  = av.readdata[31:16];
  assign done    = (state != IDLE) && !av.waitrequest;
  assign tx_head = tx_mem[tx_rd];

  assign in_consume_en = in_canPeek && (tx_count != TX_FULL);
  assign out_canPeek   = (rx_count != '0);
  assign out_peek      = out_canPeek ? rx_mem[rx_rd] : 8'h00;

  assign rx_push = (state == RD_DATA) && done && av.readdata[15];
  assign rx_pop  = out_consume_en && out_canPeek;
  assign tx_push = in_consume_en;
  assign tx_pop  = (state == WR_DATA) && done && !crlf_insert;

`ifdef JTAG_BRIDGE_CRLF_EN
  logic cr_sent;
  assign crlf_insert = (tx_head == 8'h0A) && !cr_sent;
  assign wr_byte     = crlf_insert ? 8'h0D : tx_head;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cr_sent <= 1'b0;
    else if ((state == WR_DATA) && done)
      cr_sent <= crlf_insert;
  end
`else
  assign crlf_insert = 1'b0;
  assign wr_byte     = tx_head;
`endif

  // Storage is not reset; emptiness is tracked solely by the counters.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr] <= av.readdata[7:0];
    if (tx_push) tx_mem[tx_wr] <= in_peek;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_rd <= '0;  rx_wr <= '0;  rx_count <= '0;
      tx_rd <= '0;  tx_wr <= '0;  tx_count <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RX_LOG'(1);
      if (rx_pop)  rx_rd <= rx_rd + RX_LOG'(1);
      if (tx_push) tx_wr <= tx_wr + TX_LOG'(1);
      if (tx_pop)  tx_rd <= tx_rd + TX_LOG'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_LOG+1)'(1);
        2'b01:   rx_count <= rx_count - (RX_LOG+1)'(1);
        default: rx_count <= rx_count;
      endcase
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TX_LOG+1)'(1);
        2'b01:   tx_count <= tx_count - (TX_LOG+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  assign rx_elig = (rx_count != RX_FULL) && (backoff == 16'd0);
  assign tx_elig = (tx_count != '0);
  assign pick_tx = tx_elig && (!rx_elig || rr_tx);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_tx)
          state_nxt = (credit != 16'd0) ? WR_DATA : RD_CTRL;
        else if (rx_elig)
          state_nxt = RD_DATA;
      end
      default: if (!av.waitrequest) state_nxt = IDLE;
    endcase
  end

  // Bus outputs decode straight from the state so a reset drops them at once.
  always_comb begin
    av.read      = 1'b0;
    av.write     = 1'b0;
    av.address   = 3'd0;
    av.writedata = 32'h0;
    case (state)
      RD_DATA: av.read = 1'b1;
      RD_CTRL: begin
        av.read    = 1'b1;
        av.address = 3'd4;
      end
      WR_DATA: begin
        av.write     = 1'b1;
        av.writedata = {24'h0, wr_byte};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      credit  <= 16'd0;
      backoff <= 16'd0;
      rr_tx   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (done) rr_tx <= ~rr_tx;
      if ((state == RD_DATA) && done && !av.readdata[15])
        backoff <= GAP_W;
      else if (backoff != 16'd0)
        backoff <= backoff - 16'd1;
      if ((state == RD_CTRL) && done)
        credit <= (wspace > CREDIT_W) ? CREDIT_W : wspace;
      else if ((state == WR_DATA) && done)
        credit <= credit - 16'd1;
    end
  end
endmodule

// File: tb/tb_jtag_uart_bridge.sv
// tb/tb_jtag_uart_bridge.sv - Self-checking bench for jtag_uart_bridge with an Avalon JTAG UART slave model
module tb_jtag_uart_bridge;
  localparam int POLL_GAP = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_canPeek = 1'b0;
  logic [7:0] in_peek = 8'h00;
  logic       in_consume_en;
  logic       out_canPeek;
  logic [7:0] out_peek;
  logic       out_consume_en = 1'b0;

  jtag_uart_bridge_if av();

  jtag_uart_bridge #(
    .RX_LOG(4), .TX_LOG(4), .POLL_GAP(POLL_GAP), .CREDIT_MAX(64)
  ) dut (
    .clock(clock),
    .reset(reset),
    .av(av),
    .in_canPeek(in_canPeek),
    .in_peek(in_peek),
    .in_consume_en(in_consume_en),
    .out_canPeek(out_canPeek),
    .out_peek(out_peek),
    .out_consume_en(out_consume_en)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_wr;
    logic [2:0]  addr;
    logic [31:0] data;
    int          start;
    int          done;
  } txn_t;

  typedef struct {
    logic [15:0] wspace;
    int          nbytes;
    int          exp_ctrl;
    int          exp_wr;
    int          exp_pre;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  txn_t        log_q[$];
  logic [7:0]  src_q[$];
  int          src_idx = 0;
  bit          acc_pending = 1'b0;
  int          rx_left = 0;
  logic [7:0]  rx_byte = 8'h00;
  bit          rx_inc = 1'b0;
  logic [15:0] wspace = 16'h0;
  int          hold_left = 0;
  bit          in_wr = 1'b0;
  bit          holding = 1'b0;
  int          w_start = 0;
  logic [2:0]  h_addr;
  logic [31:0] h_data;
  int          stab_bad = 0;

  initial begin
    av.waitrequest = 1'b0;
    av.readdata    = 32'h0;
  end

  // CPU TX source and Avalon slave model, evaluated mid-cycle
  always @(negedge clock) begin
    cyc++;
    if (acc_pending) src_idx++;
    acc_pending = 1'b0;
    in_canPeek = (src_idx < src_q.size());
    in_peek    = in_canPeek ? src_q[src_idx] : 8'h00;
    av.waitrequest = 1'b0;
    av.readdata    = 32'h0;
    if (av.write && !in_wr) begin
      in_wr   = 1'b1;
      w_start = cyc;
    end
    if (av.write && hold_left > 0) begin
      av.waitrequest = 1'b1;
      hold_left--;
      if (!holding) begin
        holding = 1'b1;
        h_addr  = av.address;
        h_data  = av.writedata;
      end else if (av.address !== h_addr || av.writedata !== h_data) begin
        stab_bad++;
      end
    end else if (av.read) begin
      if (av.address == 3'd4)
        av.readdata = {wspace, 16'h0};
      else if (rx_left > 0)
        av.readdata = 32'h0001_8000 | {24'h0, rx_byte};
    end
    if ((av.read || av.write) && !av.waitrequest) begin
      log_q.push_back('{av.write, av.address, av.write ? av.writedata : av.readdata,
                        av.write ? w_start : cyc, cyc});
      if (av.write) begin
        if (holding && (av.address !== h_addr || av.writedata !== h_data)) stab_bad++;
        in_wr   = 1'b0;
        holding = 1'b0;
      end else if (av.address == 3'd0 && rx_left > 0) begin
        rx_left--;
        if (rx_inc) rx_byte++;
      end
    end
    #4;
    acc_pending = in_consume_en && !reset;
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clock);
      #2;
    end
  endtask

  // kind: 0 data read, 1 control read, 2 write, 3 data read with RVALID
  function automatic int n_kind(int kind);
    int n = 0;
    foreach (log_q[i]) begin
      case (kind)
        0: if (!log_q[i].is_wr && log_q[i].addr == 3'd0) n++;
        1: if (!log_q[i].is_wr && log_q[i].addr == 3'd4) n++;
        2: if (log_q[i].is_wr) n++;
        default: if (!log_q[i].is_wr && log_q[i].addr == 3'd0 && log_q[i].data[15]) n++;
      endcase
    end
    return n;
  endfunction

  task automatic wait_cnt(int kind, int target, int budget, string name);
    int t = 0;
    while (n_kind(kind) < target && t < budget) begin
      tick(1);
      t++;
    end
    check(name, 32'(n_kind(kind) >= target), 32'd1);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    out_consume_en = 1'b0;
    tick(2);
    src_q.delete();
    src_idx = 0;
    log_q.delete();
    rx_left = 0; rx_inc = 1'b0; rx_byte = 8'h00;
    hold_left = 0; in_wr = 1'b0; holding = 1'b0; stab_bad = 0;
    tick(1);
    reset = 1'b0;
  endtask

  vec_t vecs[4];
  int   starts[$];
  int   bad, pre, nctrl, t;
  logic [7:0] exp_w[$];
  logic [7:0] got_w[$];

  initial begin
    vecs[0] = '{16'h0003, 5, 2, 5, 3};
    vecs[1] = '{16'h0400, 70, 2, 70, 64};
    vecs[2] = '{16'h0001, 2, 2, 2, 1};
    vecs[3] = '{16'h0040, 64, 1, 64, -1};

    // Reset state, with a byte offered so in_consume_en reflects an empty TX FIFO
    src_q.push_back(8'hAA);
    tick(3);
    check("rst_read", 32'(av.read), 32'd0);
    check("rst_write", 32'(av.write), 32'd0);
    check("rst_address", 32'(av.address), 32'd0);
    check("rst_writedata", av.writedata, 32'd0);
    check("rst_out_canPeek", 32'(out_canPeek), 32'd0);
    check("rst_out_peek", 32'(out_peek), 32'd0);
    check("rst_in_consume_en", 32'(in_consume_en), 32'd1);

    // Idle polling: POLL_GAP+1 quiet cycles between data reads
    reset_dut();
    tick(60);
    starts.delete();
    foreach (log_q[i]) if (!log_q[i].is_wr && log_q[i].addr == 3'd0) starts.push_back(log_q[i].start);
    check("idle_poll_count", 32'(starts.size() >= 3), 32'd1);
    if (starts.size() >= 3) begin
      check("idle_gap0", 32'(starts[1] - starts[0] - 1), 32'(POLL_GAP + 1));
      check("idle_gap1", 32'(starts[2] - starts[1] - 1), 32'(POLL_GAP + 1));
    end
    check("idle_no_writes", 32'(n_kind(2)), 32'd0);
    check("idle_out_canPeek", 32'(out_canPeek), 32'd0);

    // Three valid RX polls then drain
    rx_byte = 8'h41; rx_left = 3;
    t = 0;
    while (rx_left > 0 && t < 100) begin tick(1); t++; end
    check("rx3_timeout", 32'(rx_left), 32'd0);
    tick(2);
    check("rx3_canPeek", 32'(out_canPeek), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rx3_byte%0d", k), 32'(out_peek), 32'h41);
      out_consume_en = 1'b1;
      tick(1);
      out_consume_en = 1'b0;
    end
    check("rx3_empty", 32'(out_canPeek), 32'd0);
    out_consume_en = 1'b1;
    tick(1);
    out_consume_en = 1'b0;
    check("rx_empty_pop_ignored", 32'(out_canPeek), 32'd0);
    rx_byte = 8'h42; rx_left = 1;
    t = 0;
    while (!out_canPeek && t < 100) begin tick(1); t++; end
    check("rx_after_empty_pop", 32'(out_peek), 32'h42);

    // TX credit vectors
    foreach (vecs[i]) begin
      reset_dut();
      wspace = vecs[i].wspace;
      for (int b = 0; b < vecs[i].nbytes; b++) src_q.push_back(8'h10 + 8'(b));
      wait_cnt(2, vecs[i].nbytes, 4000, $sformatf("v%0d_timeout", i));
      tick(5);
      check($sformatf("v%0d_ctrl_reads", i), 32'(n_kind(1)), 32'(vecs[i].exp_ctrl));
      check($sformatf("v%0d_writes", i), 32'(n_kind(2)), 32'(vecs[i].exp_wr));
      bad = 0; t = 0; pre = 0; nctrl = 0;
      foreach (log_q[j]) begin
        if (log_q[j].is_wr) begin
          if (log_q[j].data !== 32'(8'h10 + 8'(t))) bad++;
          t++;
          if (nctrl < 2) pre++;
        end else if (log_q[j].addr == 3'd4) begin
          nctrl++;
        end
      end
      check($sformatf("v%0d_wr_order", i), 32'(bad), 32'd0);
      if (vecs[i].exp_pre >= 0)
        check($sformatf("v%0d_wr_before_ctrl2", i), 32'(pre), 32'(vecs[i].exp_pre));
    end

    // RX full stops polling; one pop allows exactly one read
    reset_dut();
    rx_byte = 8'h80; rx_inc = 1'b1; rx_left = 1000;
    wait_cnt(3, 16, 400, "full_fill_timeout");
    tick(5);
    log_q.delete();
    tick(60);
    check("full_no_reads", 32'(n_kind(0)), 32'd0);
    check("full_head", 32'(out_peek), 32'h80);
    out_consume_en = 1'b1;
    tick(1);
    out_consume_en = 1'b0;
    tick(60);
    check("full_one_read", 32'(n_kind(0)), 32'd1);
    check("full_head_after_pop", 32'(out_peek), 32'h81);

    // waitrequest held during a write
    rx_left = 0;
    log_q.delete();
    wspace = 16'h0008; hold_left = 5;
    src_q.push_back(8'h5A);
    src_q.push_back(8'h5B);
    wait_cnt(2, 2, 200, "hold_timeout");
    got_w.delete();
    foreach (log_q[j]) if (log_q[j].is_wr) begin
      got_w.push_back(log_q[j].data[7:0]);
      if (got_w.size() == 1) check("hold_cycles", 32'(log_q[j].done - log_q[j].start), 32'd5);
    end
    if (got_w.size() >= 2) begin
      check("hold_wr0", 32'(got_w[0]), 32'h5A);
      check("hold_wr1", 32'(got_w[1]), 32'h5B);
    end
    check("hold_stable", 32'(stab_bad), 32'd0);

    // Asynchronous reset in the middle of a held write
    check("pre_reset_rx_full", 32'(out_canPeek), 32'd1);
    log_q.delete();
    hold_left = 10;
    src_q.push_back(8'h66);
    t = 0;
    while (!av.write && t < 100) begin tick(1); t++; end
    check("areset_write_seen", 32'(av.write), 32'd1);
    tick(2);
    #1 reset = 1'b1;
    #1;
    check("areset_write_drop", 32'(av.write), 32'd0);
    check("areset_read_drop", 32'(av.read), 32'd0);
    hold_left = 0; in_wr = 1'b0; holding = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(40);
    check("areset_rx_empty", 32'(out_canPeek), 32'd0);
    check("areset_tx_empty", 32'(n_kind(2)), 32'd0);

    // LF handling
    reset_dut();
    wspace = 16'h0008;
    exp_w.delete();
`ifdef JTAG_BRIDGE_CRLF_EN
    exp_w.push_back(8'h0D);
`endif
    exp_w.push_back(8'h0A);
    exp_w.push_back(8'h41);
    src_q.push_back(8'h0A);
    src_q.push_back(8'h41);
    wait_cnt(2, exp_w.size(), 300, "lf_timeout");
    tick(20);
    check("lf_write_count", 32'(n_kind(2)), 32'(exp_w.size()));
    got_w.delete();
    foreach (log_q[j]) if (log_q[j].is_wr) got_w.push_back(log_q[j].data[7:0]);
    foreach (exp_w[k])
      if (k < got_w.size()) check($sformatf("lf_byte%0d", k), 32'(got_w[k]), 32'(exp_w[k]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/jtag_uart_bridge.md
Name: jtag_uart_bridge

Overview:
- Parametrised successor to the fixed JTAG UART byte-stream adaptor.
- Avalon-MM master that polls the JTAG UART slave. Buffers received bytes and bytes to transmit in FIFOs of configurable depth. Exposes peek/consume byte streams to the CPU.
- Adds write-space credit caching and idle-poll backoff, so the Avalon bus is not saturated when traffic is absent.

Parameters:
RX_LOG, 4, log2 of RX FIFO depth (16 entries)
TX_LOG, 4, log2 of TX FIFO depth (16 entries)
POLL_GAP, 16, idle cycles inserted after an RX poll returns no data, 1..65535
CREDIT_MAX, 64, saturation limit for cached WSPACE credit, 1..65535

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high
address  output  3  Avalon byte address: 0 = data reg, 4 = control reg
writedata  output  32  Avalon write data
write  output  1  Avalon write request
read  output  1  Avalon read request
waitrequest  input  1  Avalon stall
readdata  input  32  Avalon read data, valid in a read cycle with waitrequest low
in_canPeek  input  1  CPU TX stream has a byte
in_peek  input  8  CPU TX byte
in_consume_en  output  1  bridge accepts in_peek this cycle
out_canPeek  output  1  RX FIFO non-empty
out_peek  output  8  RX FIFO head byte
out_consume_en  input  1  CPU pops RX head

Behaviour:
- Clock is named clock; reset is asynchronous and active-high and is named reset.
- Reset state:
  - read=write=0, address=0, writedata=0.
  - Both FIFOs empty, so out_canPeek=0 and out_peek=0.
  - credit=0, backoff counter=0, FSM=IDLE, round-robin flag=RX.
- Reset asserted mid-transaction aborts it immediately. read and write drop asynchronously and no FIFO state is retained.
- TX stream:
  - in_consume_en = in_canPeek & (TX count < depth), combinational.
  - A push never occurs when the FIFO was full at the start of the cycle, even if a pop happens in the same cycle.
- RX stream:
  - out_peek is the head entry, registered FIFO storage.
  - out_consume_en while empty is ignored.
  - A push and a pop in the same cycle both take effect.
- FSM states: IDLE, RD_DATA, RD_CTRL, WR_DATA. Exactly one idle cycle separates Avalon transactions.
- IDLE decision:
  - RX eligible: RX not full and backoff counter = 0.
  - TX eligible: TX non-empty.
  - If both are eligible, the round-robin flag picks the side; the flag flips after each transaction.
  - RX chosen -> RD_DATA.
  - TX chosen with credit > 0 -> WR_DATA.
  - TX chosen with credit = 0 -> RD_CTRL.
- RD_DATA:
  - Drive read=1, address=0. Hold all outputs stable while waitrequest=1.
  - On completion, if readdata[15] (RVALID) = 1, push readdata[7:0]. Space is guaranteed because entry required not-full.
  - If RVALID = 0, load the backoff counter with POLL_GAP. It decrements each cycle to 0.
- RD_CTRL:
  - Drive read=1, address=4.
  - On completion, credit <= min(readdata[31:16] (WSPACE), CREDIT_MAX).
  - If WSPACE=0, credit stays 0 and the next TX attempt re-reads control.
- WR_DATA:
  - Drive write=1, address=0, writedata={24'b0, TX head}.
  - On completion, pop TX and decrement credit.
- Backoff applies only to RX. TX proceeds during backoff.
- Credit is 16 bits and never underflows, because WR_DATA is entered only when credit > 0.

Optional Feature:
- Macro: JTAG_BRIDGE_CRLF_EN.
- Defined:
  - When the TX head is 0x0A and the internal cr_sent flag is 0, WR_DATA writes 0x0D, does not pop, and sets cr_sent.
  - The next WR_DATA writes 0x0A, pops, and clears cr_sent.
  - Each write consumes one credit. cr_sent resets to 0.
- Undefined: bytes are written verbatim and no cr_sent state exists.

Test Plan:
- Reset then idle, with readdata RVALID=0 and waitrequest=0 -> consecutive RD_DATA reads at address 0 are separated by POLL_GAP+1 cycles (17); no writes; out_canPeek=0.
- Slave returns readdata=0x0001_8041 for 3 polls -> RX receives 0x41 three times; out_canPeek=1; three out_consume_en pulses give 0x41, 0x41, 0x41, then out_canPeek=0.
- CPU sends 5 bytes 0x10..0x14; control returns WSPACE=0x0003 -> one control read, three writes (0x10, 0x11, 0x12), a second control read, then the remaining two writes.
- WSPACE=0x0400 with CREDIT_MAX=64 -> credit=64; 70 queued bytes trigger exactly 2 control reads.
- waitrequest held high 5 cycles during WR_DATA -> address, writedata and write stay stable; pop happens only on the release cycle. Async reset pulsed mid-hold -> write=0 immediately; FIFOs are empty afterwards.
- RX full (16 entries, no consume) -> no RD_DATA issued. One consume -> exactly one read follows. With JTAG_BRIDGE_CRLF_EN, TX byte 0x0A -> writes 0x0D then 0x0A.
